rst_seq_gen: RTL and testbench

//   Reset request generator and release sequencer: the source side of the reset tree.

---
 rtl/rst_seq_gen.sv | 186 ++++++++++++++++++
 tb/tb_rst_seq_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//   Source side of the reset tree. Produces a minimum-width reset pulse from
//   either the block reset or a debounced request level, then releases
//   NUM_STAGES active-high reset outputs one at a time, bit 0 first, spaced
//   STAGE_GAP cycles apart. A held request during the release phase aborts
//   and restarts the whole sequence.
//
// Ports
//   clk_in   in   1           single clock for the whole block
//   rst_in   in   1           synchronous reset, active-high
//   req_in   in   1           reset request level, synchronous to clk_in
//   rst_out  out  NUM_STAGES  active-high resets; bit 0 releases first
//   busy     out  1           high while a sequence is in progress
//   done     out  1           one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module rst_seq_gen #(
    parameter int NUM_STAGES   = 3,
    parameter int PULSE_CYC    = 16,
    parameter int STAGE_GAP    = 8,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_in,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  busy,
    output logic                  done
);

    // Cycle (counted from cycle 0 of a sequence) at which done fires.
    localparam int T_CYC  = PULSE_CYC + (NUM_STAGES - 1) * STAGE_GAP + 1;
    localparam int CNT_W  = $clog2(T_CYC) + 1;
    localparam int DCNT_W = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  PULSE_END = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0]  T_END     = CNT_W'(T_CYC);
    localparam logic [DCNT_W-1:0] DEB_END   = DCNT_W'(DEBOUNCE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [DCNT_W-1:0]       dcnt_reg, dcnt_next;
    logic                    armed_reg, armed_next;
    logic                    hold_reg, hold_next;
    logic [NUM_STAGES-1:0]   rst_out_reg, rst_out_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    // cnt_reg holds the cycle number of the most recent edge, so cnt_inc is
    // the cycle number the coming edge will have.
    logic [CNT_W-1:0]        cnt_inc;
    logic [NUM_STAGES-1:0]   stage_live;

    assign cnt_inc = cnt_reg + CNT_W'(1);

    // stage_live[k] stays high while the coming edge is still before that
    // stage's release cycle.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            localparam int REL_CYC = PULSE_CYC + gi * STAGE_GAP;
            assign stage_live[gi] = (cnt_inc < CNT_W'(REL_CYC));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        dcnt_next    = dcnt_reg;
        armed_next   = armed_reg;
        hold_next    = hold_reg;
        rst_out_next = rst_out_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                rst_out_next = '0;
                busy_next    = 1'b0;
                // Saturate rather than wrap so a long idle period is harmless.
                cnt_next     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_inc;
                if (dcnt_reg == DEB_END) begin
                    // Debounce satisfied on the previous edge: this edge is cycle 0.
                    state_next   = ST_ASSERT;
                    cnt_next     = '0;
                    dcnt_next    = '0;
                    armed_next   = 1'b0;
                    hold_next    = 1'b0;
                    rst_out_next = '1;
                    busy_next    = 1'b1;
                end else if (!req_in) begin
                    armed_next = 1'b1;
                    dcnt_next  = '0;
                end else if (armed_reg) begin
                    dcnt_next = dcnt_reg + DCNT_W'(1);
                end
            end

            ST_ASSERT: begin
                // Requests are ignored here; the pulse is never stretched.
                rst_out_next = '1;
                busy_next    = 1'b1;
                dcnt_next    = '0;
                if (hold_reg) begin
                    // First edge after rst_in drops is cycle 0 itself.
                    hold_next = 1'b0;
                    cnt_next  = '0;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == PULSE_END) begin
                        state_next   = ST_RELEASE;
                        rst_out_next = rst_out_reg & stage_live;
                    end
                end
            end

            ST_RELEASE: begin
                busy_next = 1'b1;
                if (dcnt_reg == DEB_END) begin
                    // Abort: restart the full pulse; no arming needed here.
                    state_next   = ST_ASSERT;
                    cnt_next     = '0;
                    dcnt_next    = '0;
                    hold_next    = 1'b0;
                    rst_out_next = '1;
                end else begin
                    cnt_next     = cnt_inc;
                    dcnt_next    = req_in ? (dcnt_reg + DCNT_W'(1)) : '0;
                    // AND keeps released stages low for the rest of the sequence.
                    rst_out_next = rst_out_reg & stage_live;
                    if (cnt_inc == T_END) begin
                        state_next   = ST_IDLE;
                        rst_out_next = '0;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                        dcnt_next    = '0;
                        armed_next   = 1'b0;
                    end
                end
            end

            default: begin
                state_next   = ST_ASSERT;
                cnt_next     = '0;
                dcnt_next    = '0;
                armed_next   = 1'b0;
                hold_next    = 1'b0;
                rst_out_next = '1;
                busy_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg   <= ST_ASSERT;
            cnt_reg     <= '0;
            dcnt_reg    <= '0;
            armed_reg   <= 1'b0;
            hold_reg    <= 1'b1;
            rst_out_reg <= '1;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dcnt_reg    <= dcnt_next;
            armed_reg   <= armed_next;
            hold_reg    <= hold_next;
            rst_out_reg <= rst_out_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign rst_out = rst_out_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
//   Directed bench for rst_seq_gen: default configuration (3,16,8,4) plus a
//   single-stage instance with a 2-cycle pulse.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

    logic       clk;
    logic       rst;
    logic       req;
    logic [2:0] rst_out;
    logic       busy;
    logic       done;

    logic       rst1;
    logic       req1;
    logic [0:0] rst_out1;
    logic       busy1;
    logic       done1;

    int checks = 0;
    int errors = 0;

    rst_seq_gen #(
        .NUM_STAGES  (3),
        .PULSE_CYC   (16),
        .STAGE_GAP   (8),
        .DEBOUNCE_CYC(4)
    ) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .req_in (req),
        .rst_out(rst_out),
        .busy   (busy),
        .done   (done)
    );

    rst_seq_gen #(
        .NUM_STAGES  (1),
        .PULSE_CYC   (2),
        .STAGE_GAP   (8),
        .DEBOUNCE_CYC(4)
    ) u_dut1 (
        .clk_in (clk),
        .rst_in (rst1),
        .req_in (req1),
        .rst_out(rst_out1),
        .busy   (busy1),
        .done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle outputs before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {done, busy, rst_out} at cycle c of a default-config sequence.
    function automatic logic [4:0] exp_out(input int c);
        if (c < 16)       return 5'b0_1_111;
        else if (c < 24)  return 5'b0_1_110;
        else if (c < 32)  return 5'b0_1_100;
        else if (c == 32) return 5'b0_1_000;
        else if (c == 33) return 5'b1_0_000;
        else              return 5'b0_0_000;
    endfunction

    // Step through cycles from..upto of a sequence, checking every edge.
    task automatic follow(input string tag, input int from, input int upto);
        for (int c = from; c <= upto; c++) begin
            step();
            check_eq($sformatf("%s c%0d", tag, c), {27'd0, done, busy, rst_out}, {27'd0, exp_out(c)});
        end
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_eq($sformatf("%s idle%0d", tag, i), {27'd0, done, busy, rst_out}, 32'b0_0_000);
        end
    endtask

    // Four high samples in IDLE; the following edge is cycle 0.
    task automatic trigger(input string tag);
        req = 1'b1;
        idle_steps(tag, 4);
        req = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        rst1 = 1'b1;
        req1 = 1'b0;

        // 1. Power-up
        repeat (5) step();
        check_eq("reset state", {27'd0, done, busy, rst_out}, 32'b0_1_111);
        rst = 1'b0;
        follow("pwr", 0, 36);
        $display("test 1 power-up sequence done");

        // 2. Debounce: three highs do nothing, four trigger
        req = 1'b1;
        idle_steps("deb3", 3);
        req = 1'b0;
        idle_steps("deb3 low", 2);
        trigger("deb4");
        follow("deb", 0, 36);
        $display("test 2 debounce done");

        // 3. Abort during release
        trigger("abt trig");
        follow("abt", 0, 24);
        req = 1'b1;
        follow("abt req", 25, 28);
        req = 1'b0;
        follow("abt new", 0, 36);
        $display("test 3 abort done");

        // 4. Re-arm: request held across done must not retrigger
        trigger("arm trig");
        follow("arm", 0, 30);
        req = 1'b1;
        follow("arm hi", 31, 33);
        idle_steps("arm held", 10);
        req = 1'b0;
        idle_steps("arm drop", 1);
        trigger("arm re");
        follow("arm new", 0, 36);
        $display("test 4 re-arm done");

        // 5. Reset mid-sequence, then a request inside ASSERT is ignored
        trigger("mid trig");
        follow("mid", 0, 19);
        rst = 1'b1;
        step();
        check_eq("mid rst c20", {27'd0, done, busy, rst_out}, 32'b0_1_111);
        rst = 1'b0;
        follow("mid new", 0, 4);
        req = 1'b1;
        follow("mid asrt req", 5, 10);
        req = 1'b0;
        follow("mid new", 11, 36);
        $display("test 5 reset mid-sequence done");

        // 6. Single stage, 2-cycle pulse
        repeat (2) step();
        check_eq("s1 reset", {29'd0, done1, busy1, rst_out1}, 32'b0_1_1);
        rst1 = 1'b0;
        step(); check_eq("s1 c0", {29'd0, done1, busy1, rst_out1}, 32'b0_1_1);
        step(); check_eq("s1 c1", {29'd0, done1, busy1, rst_out1}, 32'b0_1_1);
        step(); check_eq("s1 c2", {29'd0, done1, busy1, rst_out1}, 32'b0_1_0);
        step(); check_eq("s1 c3", {29'd0, done1, busy1, rst_out1}, 32'b1_0_0);
        step(); check_eq("s1 c4", {29'd0, done1, busy1, rst_out1}, 32'b0_0_0);
        $display("test 6 single stage done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
